// File: rtl/tmrbr_pkg.sv
// Shared types for the 32-to-16 timer bridge: FSM states, half selectors, latency counter width.
// Optional TMRBR_BE_SKIP_EN: see timer_avalon_32to16_bridge.sv.
package tmrbr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_LO   = 3'd1,
    WR_HI   = 3'd2,
    RD_LO   = 3'd3,
    RD_LO_W = 3'd4,
    RD_HI   = 3'd5,
    RD_HI_W = 3'd6,
    DONE    = 3'd7
  } state_e;

  localparam logic HALF_LO   = 1'b0;
  localparam logic HALF_HI   = 1'b1;
  localparam int   LAT_CNT_W = 3;

  // First state of a write given which halves are enabled.
  function automatic state_e wr_entry(input logic lo_en, input logic hi_en);
    if (lo_en)      return WR_LO;
    else if (hi_en) return WR_HI;
    else            return DONE;
  endfunction

endpackage

// File: rtl/timer_avalon_32to16_bridge.sv
// 32-bit Avalon slave to 16-bit interval-timer master: each access becomes a low-half then high-half
// timer access. Define TMRBR_BE_SKIP_EN to skip write halves whose byte enables are all zero.
module timer_avalon_32to16_bridge
  import tmrbr_pkg::*;
#(
  parameter int S_ADDR_W     = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_chipselect,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [S_ADDR_W-1:0] s_address,
  input  logic [3:0]          s_byteenable,
  input  logic [31:0]         s_writedata,
  output logic [31:0]         s_readdata,
  output logic                s_waitrequest,
  output logic                s_irq,
  output logic                m_chipselect,
  output logic                m_write_n,
  output logic [S_ADDR_W:0]   m_address,
  output logic [15:0]         m_writedata,
  input  logic [15:0]         m_readdata,
  input  logic                m_irq
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LATENCY - 1);

  state_e                state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [S_ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  m_cs_q, m_cs_d;
  logic                  m_write_n_q, m_write_n_d;
  logic [S_ADDR_W:0]     m_addr_q, m_addr_d;
  logic [15:0]           m_wdata_q, m_wdata_d;

  logic                  req;
  logic                  lo_en_in, hi_en_in, hi_en_cur;

`ifdef TMRBR_BE_SKIP_EN
  logic [3:0] be_q, be_d;

  always_comb be_d = (state_q == IDLE) ? s_byteenable : be_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) be_q <= '0;
    else          be_q <= be_d;
  end

  assign lo_en_in  = |s_byteenable[1:0];
  assign hi_en_in  = |s_byteenable[3:2];
  assign hi_en_cur = |be_q[3:2];
`else
  logic unused_be;
  assign unused_be = ^s_byteenable;
  assign lo_en_in  = 1'b1;
  assign hi_en_in  = 1'b1;
  assign hi_en_cur = 1'b1;
`endif

  assign req           = s_chipselect & (s_read | s_write);
  assign s_waitrequest = req & (state_q != DONE);
  assign s_irq         = m_irq;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = s_address;
          wdata_d = s_writedata;
          // Write wins when both strobes are raised.
          state_d = s_write ? wr_entry(lo_en_in, hi_en_in) : RD_LO;
        end
      end
      WR_LO:   state_d = hi_en_cur ? WR_HI : DONE;
      WR_HI:   state_d = DONE;
      RD_LO: begin
        state_d = RD_LO_W;
        cnt_d   = LAT_LOAD;
      end
      RD_LO_W: begin
        if (cnt_q == '0) begin
          rdata_d[15:0] = m_readdata;
          state_d       = RD_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_HI: begin
        state_d = RD_HI_W;
        cnt_d   = LAT_LOAD;
      end
      RD_HI_W: begin
        if (cnt_q == '0) begin
          rdata_d[31:16] = m_readdata;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered, so they are decoded from the state being entered.
  always_comb begin
    m_cs_d      = 1'b0;
    m_write_n_d = 1'b1;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    unique case (state_d)
      WR_LO: begin
        m_cs_d      = 1'b1;
        m_write_n_d = 1'b0;
        m_addr_d    = {addr_d, HALF_LO};
        m_wdata_d   = wdata_d[15:0];
      end
      WR_HI: begin
        m_cs_d      = 1'b1;
        m_write_n_d = 1'b0;
        m_addr_d    = {addr_d, HALF_HI};
        m_wdata_d   = wdata_d[31:16];
      end
      RD_LO: begin
        m_cs_d   = 1'b1;
        m_addr_d = {addr_d, HALF_LO};
      end
      RD_HI: begin
        m_cs_d   = 1'b1;
        m_addr_d = {addr_d, HALF_HI};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      m_cs_q      <= 1'b0;
      m_write_n_q <= 1'b1;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      m_cs_q      <= m_cs_d;
      m_write_n_q <= m_write_n_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
    end
  end

  assign s_readdata   = rdata_q;
  assign m_chipselect = m_cs_q;
  assign m_write_n    = m_write_n_q;
  assign m_address    = m_addr_q;
  assign m_writedata  = m_wdata_q;

endmodule
